// File: rtl/i2c_temp_pkg.sv
// Shared types and constants for the I2C temperature poller.
// Register map of the sensor plus the sequencer state encoding.
package i2c_temp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_WAIT_PERIOD,
    ST_RD_MSB_ISSUE,
    ST_RD_MSB_WAIT,
    ST_RD_LSB_ISSUE,
    ST_RD_LSB_WAIT,
    ST_PUBLISH,
    ST_FAULT
  } poller_state_t;

  localparam logic [7:0] TEMP_MSB_REG = 8'h00;
  localparam logic [7:0] TEMP_LSB_REG = 8'h01;
  localparam logic [7:0] CONFIG_REG   = 8'h03;

  // Width able to hold the larger of two cycle counts.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired while the count sits at zero.
// Loading N-1 on state entry gives an expiry in the Nth cycle.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/i2c_temp_poller.sv
// Sequencer owning the I2C wrapper command port: configures the
// sensor once, then polls both temperature bytes every period.
module i2c_temp_poller
  import i2c_temp_pkg::*;
#(
  parameter int         CLK_FREQ       = 100_000_000,
  parameter logic [6:0] DEV_ADDR       = 7'h4B,
  parameter logic [7:0] CFG_REG        = CONFIG_REG,
  parameter logic [7:0] CFG_VALUE      = 8'h80,
  parameter int         POLL_CYCLES    = 25_000_000,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        i2c_start,
  output logic        i2c_rd_wr,
  output logic [7:0]  i2c_reg_addr,
  output logic [6:0]  i2c_bus_addr,
  output logic [7:0]  i2c_wr_data,
  input  logic [7:0]  i2c_rd_data,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_error,
  output logic [15:0] temp_raw,
  output logic [8:0]  temp_int,
  output logic        temp_valid,
  output logic        fault
);

  localparam int CNT_W = cnt_width(POLL_CYCLES, TIMEOUT_CYCLES);
  localparam int RTY_W = $clog2(MAX_RETRIES + 2);
  localparam logic [CNT_W-1:0] POLL_LOAD = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

  if (CLK_FREQ <= 0) begin : g_bad_clk
    $error("CLK_FREQ must be positive");
  end

  poller_state_t state_q, state_d;

  logic             start_q, start_d;
  logic             rd_wr_q, rd_wr_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdat_q, wdat_d;
  logic [7:0]       msb_q, msb_d;
  logic [15:0]      raw_q, raw_d;
  logic [8:0]       tint_q, tint_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             cfgd_q, cfgd_d;
  logic [RTY_W-1:0] rty_q, rty_d;

  logic poll_exp, tmo_exp;
  logic poll_load, tmo_load;
  logic txn_ok, txn_fail, rty_exh;

  assign txn_ok   = i2c_done && !i2c_error;
  assign txn_fail = i2c_error || (tmo_exp && !i2c_done);
  assign rty_exh  = (int'(rty_q) + 1) > MAX_RETRIES;

  assign poll_load = (state_d != state_q) &&
                     (state_d == ST_WAIT_PERIOD ||
                      state_d == ST_FAULT);
  assign tmo_load  = (state_d != state_q) &&
                     (state_d == ST_CFG_WAIT ||
                      state_d == ST_RD_MSB_WAIT ||
                      state_d == ST_RD_LSB_WAIT);

  cycle_timer #(.W(CNT_W)) u_poll (
    .clk        (clk),
    .rst        (rst),
    .load_i     (poll_load),
    .load_val_i (POLL_LOAD),
    .expired_o  (poll_exp)
  );

  cycle_timer #(.W(CNT_W)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .expired_o  (tmo_exp)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; any read failure restarts at the MSB read.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = cfgd_q ? ST_RD_MSB_ISSUE : ST_CFG_ISSUE;
        end
      end
      ST_CFG_ISSUE: begin
        if (!i2c_busy) state_d = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (txn_fail) begin
          state_d = rty_exh ? ST_FAULT : ST_CFG_ISSUE;
        end else if (txn_ok) begin
          state_d = ST_WAIT_PERIOD;
        end
      end
      ST_WAIT_PERIOD: begin
        if (poll_exp) begin
          state_d = enable ? ST_RD_MSB_ISSUE : ST_IDLE;
        end
      end
      ST_RD_MSB_ISSUE: begin
        if (!i2c_busy) state_d = ST_RD_MSB_WAIT;
      end
      ST_RD_MSB_WAIT: begin
        if (txn_fail) begin
          state_d = rty_exh ? ST_FAULT : ST_RD_MSB_ISSUE;
        end else if (txn_ok) begin
          state_d = ST_RD_LSB_ISSUE;
        end
      end
      ST_RD_LSB_ISSUE: begin
        if (!i2c_busy) state_d = ST_RD_LSB_WAIT;
      end
      ST_RD_LSB_WAIT: begin
        if (txn_fail) begin
          state_d = rty_exh ? ST_FAULT : ST_RD_MSB_ISSUE;
        end else if (txn_ok) begin
          state_d = ST_PUBLISH;
        end
      end
      ST_PUBLISH: state_d = ST_WAIT_PERIOD;
      ST_FAULT: begin
        if (poll_exp) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and flag next values; command fields hold between issues.
  always_comb begin
    start_d = 1'b0;
    rd_wr_d = rd_wr_q;
    reg_d   = reg_q;
    wdat_d  = wdat_q;
    msb_d   = msb_q;
    raw_d   = raw_q;
    tint_d  = tint_q;
    valid_d = 1'b0;
    cfgd_d  = cfgd_q;
    rty_d   = rty_q;
    fault_d = (state_d == ST_FAULT);
    unique case (state_q)
      ST_CFG_ISSUE: begin
        if (!i2c_busy) begin
          start_d = 1'b1;
          rd_wr_d = 1'b0;
          reg_d   = CFG_REG;
          wdat_d  = CFG_VALUE;
        end
      end
      ST_RD_MSB_ISSUE: begin
        if (!i2c_busy) begin
          start_d = 1'b1;
          rd_wr_d = 1'b1;
          reg_d   = TEMP_MSB_REG;
          wdat_d  = 8'h00;
        end
      end
      ST_RD_LSB_ISSUE: begin
        if (!i2c_busy) begin
          start_d = 1'b1;
          rd_wr_d = 1'b1;
          reg_d   = TEMP_LSB_REG;
          wdat_d  = 8'h00;
        end
      end
      ST_CFG_WAIT: begin
        if (txn_fail) begin
          rty_d = rty_q + RTY_W'(1);
        end else if (txn_ok) begin
          cfgd_d = 1'b1;
        end
      end
      ST_RD_MSB_WAIT: begin
        if (txn_fail) begin
          rty_d = rty_q + RTY_W'(1);
        end else if (txn_ok) begin
          msb_d = i2c_rd_data;
        end
      end
      ST_RD_LSB_WAIT: begin
        if (txn_fail) begin
          rty_d = rty_q + RTY_W'(1);
        end else if (txn_ok) begin
          raw_d   = {msb_q, i2c_rd_data};
          tint_d  = {msb_q, i2c_rd_data[7]};
          valid_d = 1'b1;
        end
      end
      ST_PUBLISH: rty_d = '0;
      ST_FAULT: begin
        if (poll_exp) begin
          cfgd_d = 1'b0;
          rty_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, capture registers and flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q <= 1'b0;
      rd_wr_q <= 1'b0;
      reg_q   <= 8'h00;
      wdat_q  <= 8'h00;
      msb_q   <= 8'h00;
      raw_q   <= 16'h0000;
      tint_q  <= 9'h000;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cfgd_q  <= 1'b0;
      rty_q   <= '0;
    end else begin
      start_q <= start_d;
      rd_wr_q <= rd_wr_d;
      reg_q   <= reg_d;
      wdat_q  <= wdat_d;
      msb_q   <= msb_d;
      raw_q   <= raw_d;
      tint_q  <= tint_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cfgd_q  <= cfgd_d;
      rty_q   <= rty_d;
    end
  end

  assign i2c_start    = start_q;
  assign i2c_rd_wr    = rd_wr_q;
  assign i2c_reg_addr = reg_q;
  assign i2c_bus_addr = DEV_ADDR;
  assign i2c_wr_data  = wdat_q;
  assign temp_raw     = raw_q;
  assign temp_int     = tint_q;
  assign temp_valid   = valid_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_i2c_temp_poller.sv
// Bench for i2c_temp_poller: scripted I2C responder, vector table,
// random samples against an arithmetic reference, corner sequences.
module tb_i2c_temp_poller;

  localparam int POLL = 200;
  localparam int TMO  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_error = 1'b0;
  logic [7:0]  i2c_rd_data = 8'h00;
  logic        i2c_start;
  logic        i2c_rd_wr;
  logic [7:0]  i2c_reg_addr;
  logic [6:0]  i2c_bus_addr;
  logic [7:0]  i2c_wr_data;
  logic [15:0] temp_raw;
  logic [8:0]  temp_int;
  logic        temp_valid;
  logic        fault;

  i2c_temp_poller #(
    .POLL_CYCLES    (POLL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .i2c_start    (i2c_start),
    .i2c_rd_wr    (i2c_rd_wr),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_bus_addr (i2c_bus_addr),
    .i2c_wr_data  (i2c_wr_data),
    .i2c_rd_data  (i2c_rd_data),
    .i2c_busy     (i2c_busy),
    .i2c_done     (i2c_done),
    .i2c_error    (i2c_error),
    .temp_raw     (temp_raw),
    .temp_int     (temp_int),
    .temp_valid   (temp_valid),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vcount = 0;
  always @(posedge clk) if (temp_valid) vcount <= vcount + 1;

  int n_pass = 0;
  int n_total = 0;

  logic       cmd_rw;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wd;
  logic [6:0] cmd_bus;
  int         prev_v = -1;

  typedef struct {
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [15:0] raw;
    logic [8:0]  ti;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  // Floor of raw/128 for a two's-complement 16-bit reading.
  function automatic int ref_int(input logic [15:0] raw);
    int t;
    t = int'(raw);
    if (raw[15]) t = t - 65536;
    if (t >= 0) return t / 128;
    return -((-t + 127) / 128);
  endfunction

  task automatic wait_start(output int at);
    at = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i2c_start === 1'b1) begin
        at = cyc;
        cmd_rw  = i2c_rd_wr;
        cmd_reg = i2c_reg_addr;
        cmd_wd  = i2c_wr_data;
        cmd_bus = i2c_bus_addr;
        break;
      end
    end
    chk("start_seen", at >= 0, 1);
  endtask

  // Called at the negedge where start was seen; returns done cycle.
  task automatic respond(input bit err,
                         input logic [7:0] data,
                         output int dat);
    int lat;
    lat = $urandom_range(2, 8);
    i2c_busy = 1'b1;
    @(negedge clk);
    chk("start_one_cycle", i2c_start, 0);
    repeat (lat - 1) @(negedge clk);
    i2c_done = 1'b1;
    i2c_error = err;
    i2c_rd_data = data;
    i2c_busy = 1'b0;
    dat = cyc;
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_error = 1'b0;
    i2c_rd_data = 8'h5A;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start"}, i2c_start, 0);
    chk({tag, "_rw"}, i2c_rd_wr, 0);
    chk({tag, "_reg"}, i2c_reg_addr, 0);
    chk({tag, "_bus"}, i2c_bus_addr, 7'h4B);
    chk({tag, "_wd"}, i2c_wr_data, 0);
    chk({tag, "_raw"}, temp_raw, 0);
    chk({tag, "_int"}, temp_int, 0);
    chk({tag, "_valid"}, temp_valid, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  task automatic do_config();
    int t, d;
    wait_start(t);
    chk("cfg_rw", cmd_rw, 0);
    chk("cfg_reg", cmd_reg, 8'h03);
    chk("cfg_wd", cmd_wd, 8'h80);
    chk("cfg_bus", cmd_bus, 7'h4B);
    respond(0, 8'h00, d);
    prev_v = d;
  endtask

  task automatic sample(input logic [7:0] msb,
                        input logic [7:0] lsb,
                        input logic [15:0] raw,
                        input logic [8:0] ti);
    int t, d, v0;
    wait_start(t);
    chk("msb_reg", cmd_reg, 8'h00);
    chk("msb_rw", cmd_rw, 1);
    if (prev_v >= 0) chk("poll_gap", t - prev_v, POLL + 2);
    respond(0, msb, d);
    wait_start(t);
    chk("lsb_reg", cmd_reg, 8'h01);
    chk("lsb_gap", t - d, 2);
    v0 = vcount;
    respond(0, lsb, d);
    chk("valid", temp_valid, 1);
    chk("temp_raw", temp_raw, raw);
    chk("temp_int", temp_int, ti);
    prev_v = cyc;
    @(negedge clk);
    chk("valid_single", temp_valid, 0);
    chk("valid_count", vcount - v0, 1);
  endtask

  initial begin
    int t, d, s, v0, fat, extra, fcnt;
    logic [7:0]  m, l;
    logic [15:0] r;

    vecs[0] = '{8'h0C, 8'h80, 16'h0C80, 9'd25};
    vecs[1] = '{8'hF3, 8'h80, 16'hF380, 9'h1E7};
    vecs[2] = '{8'h7F, 8'hFF, 16'h7FFF, 9'h0FF};
    vecs[3] = '{8'h80, 8'h00, 16'h8000, 9'h100};
    vecs[4] = '{8'hFF, 8'hFF, 16'hFFFF, 9'h1FF};

    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b1;

    do_config();

    for (int i = 0; i < 5; i++) begin
      sample(vecs[i].msb, vecs[i].lsb, vecs[i].raw, vecs[i].ti);
    end

    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom);
      l = 8'($urandom);
      r = 16'(int'(m) * 256 + int'(l));
      sample(m, l, r, 9'(ref_int(r)));
    end

    // LSB read fails (error with done): retry restarts at MSB.
    wait_start(t);
    chk("e_msb_reg", cmd_reg, 8'h00);
    chk("e_gap", t - prev_v, POLL + 2);
    v0 = vcount;
    respond(0, 8'h11, d);
    wait_start(t);
    chk("e_lsb_reg", cmd_reg, 8'h01);
    respond(1, 8'h22, d);
    wait_start(t);
    chk("e_retry_reg", cmd_reg, 8'h00);
    chk("e_retry_gap", t - d, 2);
    respond(0, 8'h0D, d);
    wait_start(t);
    chk("e_lsb2_reg", cmd_reg, 8'h01);
    respond(0, 8'h40, d);
    chk("e_valid", temp_valid, 1);
    chk("e_raw", temp_raw, 16'h0D40);
    chk("e_int", temp_int, 9'(ref_int(16'h0D40)));
    prev_v = cyc;
    @(negedge clk);
    chk("e_valid_count", vcount - v0, 1);

    // Silent bus: four timeouts, then fault for one period.
    wait_start(s);
    chk("t_reg", cmd_reg, 8'h00);
    chk("t_gap", s - prev_v, POLL + 2);
    for (int i = 0; i < 3; i++) begin
      wait_start(t);
      chk("t_retry_reg", cmd_reg, 8'h00);
      chk("t_retry_gap", t - s, TMO + 1);
      s = t;
    end
    fat = -1;
    extra = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i2c_start) extra++;
      if (fault) begin
        fat = cyc;
        break;
      end
    end
    chk("t_fault_rise", fat - s, TMO);
    chk("t_no_5th_start", extra, 0);
    fcnt = (fat >= 0) ? 1 : 0;
    for (int i = 0; i < 400 && fat >= 0; i++) begin
      @(negedge clk);
      if (fault) fcnt++;
      else break;
    end
    chk("t_fault_len", fcnt, POLL);
    chk("t_fault_clear", fault, 0);
    do_config();

    // enable drops during MSB wait: sample still published.
    wait_start(t);
    chk("n_msb_reg", cmd_reg, 8'h00);
    chk("n_gap", t - prev_v, POLL + 2);
    enable = 1'b0;
    respond(0, 8'h19, d);
    wait_start(t);
    chk("n_lsb_reg", cmd_reg, 8'h01);
    respond(0, 8'h00, d);
    chk("n_valid", temp_valid, 1);
    chk("n_raw", temp_raw, 16'h1900);
    chk("n_int", temp_int, 9'd50);
    extra = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i2c_start) extra++;
    end
    chk("n_idle_starts", extra, 0);

    // Re-enable: still configured, so straight to reading.
    enable = 1'b1;
    prev_v = -1;
    wait_start(t);
    chk("r_reg", cmd_reg, 8'h00);
    chk("r_rw", cmd_rw, 1);
    respond(0, 8'h0A, d);
    wait_start(t);
    chk("r_lsb_reg", cmd_reg, 8'h01);
    rst = 1'b0;
    @(negedge clk);
    check_reset("mid");
    rst = 1'b1;
    do_config();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_temp_poller.md
# i2c_temp_poller

Autonomous sequencer that owns the `i2c_wrapper` command port and keeps a fresh temperature reading from the on-board temperature sensor.
- After reset it writes the sensor configuration register once.
- It then reads the two temperature registers every poll period and publishes a 16-bit sample with a one-cycle valid strobe.
- It sits between `i2c_wrapper` and the display/UART logic, and is the only master of the wrapper's `start`/`rd_wr`/`address` inputs.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz (documentation only; passes through to the wrapper instance in the top level).
- `DEV_ADDR`, 7'h4B, sensor 7-bit bus address.
- `CFG_REG`, 8'h03, configuration register pointer.
- `CFG_VALUE`, 8'h80, configuration byte (16-bit resolution).
- `POLL_CYCLES`, 25_000_000, cycles from one sample publish to the next read start.
- `TIMEOUT_CYCLES`, 1_000_000, maximum cycles from start to done before a transaction counts as failed.
- `MAX_RETRIES`, 3, consecutive failures allowed before entering fault.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `enable`  in  1  run polling; when low, the block finishes the current transaction and then idles.
- `i2c_start`  out  1  one-cycle command pulse to the wrapper.
- `i2c_rd_wr`  out  1  0 = write, 1 = read.
- `i2c_reg_addr`  out  8  register pointer.
- `i2c_bus_addr`  out  7  always `DEV_ADDR`.
- `i2c_wr_data`  out  8  write byte.
- `i2c_rd_data`  in  8  read byte; valid while `i2c_done` is high.
- `i2c_busy`  in  1  wrapper busy.
- `i2c_done`  in  1  transaction-complete pulse.
- `i2c_error`  in  1  NACK/bus error pulse.
- `temp_raw`  out  16  {MSB,LSB}, two's complement, 1/128 °C per LSB.
- `temp_int`  out  9  signed integer degrees, equal to `temp_raw >>> 7`.
- `temp_valid`  out  1  one-cycle pulse when `temp_raw` updates.
- `fault`  out  1  level; retries exhausted.

## Operation
States:
- **IDLE**
  - `enable`=1 and not configured → CFG_ISSUE.
  - `enable`=1 and configured → RD_MSB_ISSUE.
- **CFG_ISSUE**: drives write of `CFG_VALUE` to `CFG_REG` → CFG_WAIT.
- **CFG_WAIT**: on success, sets the configured flag → WAIT_PERIOD.
- **WAIT_PERIOD**: counts `POLL_CYCLES`.
  - Then → RD_MSB_ISSUE if `enable`=1, otherwise → IDLE.
- **RD_MSB_ISSUE / RD_MSB_WAIT**: reads register 8'h00 and captures the MSB.
- **RD_LSB_ISSUE / RD_LSB_WAIT**: reads register 8'h01 and captures the LSB.
- **PUBLISH**: loads `temp_raw`/`temp_int`, pulses `temp_valid`, clears the retry counter → WAIT_PERIOD.
- **FAULT**: holds `fault`=1.
  - Counts `POLL_CYCLES`, then clears the configured flag and retry counter, drops `fault`, → IDLE.

Transaction rules (all ISSUE/WAIT pairs):
- An ISSUE state waits until `i2c_busy`=0.
- It then asserts `i2c_start` for exactly one cycle with `i2c_rd_wr`, `i2c_reg_addr` and `i2c_wr_data` valid in that cycle.
- These command fields hold stable until the matching WAIT state exits.
- Success in a WAIT state: `i2c_done`=1 and `i2c_error`=0.
- Failure in a WAIT state: `i2c_error`=1 (including when it coincides with done), or the timeout counter reaching `TIMEOUT_CYCLES`.

Failure handling:
- Each failure increments the retry counter.
- If the count is ≤ `MAX_RETRIES`, the block returns to the same ISSUE state. A failed LSB read restarts at RD_MSB_ISSUE, so a sample never mixes two conversions.
- Otherwise → FAULT.

Other rules:
- `enable` falling mid-transaction: the transaction completes, PUBLISH still occurs, then WAIT_PERIOD → IDLE.
- Reset at any time → IDLE with all outputs and flags cleared; the wrapper must be reset by the same `rst`.

## Timing
- Reset values: `i2c_start`=0, `i2c_rd_wr`=0, `i2c_reg_addr`=0, `i2c_bus_addr`=`DEV_ADDR`, `i2c_wr_data`=0, `temp_raw`=0, `temp_int`=0, `temp_valid`=0, `fault`=0.
- All outputs are registered.
- `i2c_start` rises one cycle after entry to an ISSUE state with `i2c_busy` low.
- `i2c_done` sampled in cycle N → next ISSUE state at N+1, start pulse at N+2.
- `temp_valid` pulses the cycle after the LSB `done`, with `temp_raw` already updated in that cycle.
- Timeout counter:
  - clears at the start pulse;
  - reaching `TIMEOUT_CYCLES`-1 with no done/error counts as failure on the next edge.
- Poll counter: zero at WAIT_PERIOD entry; exits after exactly `POLL_CYCLES` cycles in the state.
- Counter widths are `$clog2(max(POLL_CYCLES, TIMEOUT_CYCLES)+1)`.

## Structure
- Package `i2c_temp_pkg` holds:
  - state enum `poller_state_t`;
  - register pointer constants `TEMP_MSB_REG`=8'h00, `TEMP_LSB_REG`=8'h01, `CONFIG_REG`=8'h03.
- One sub-module, `cycle_timer` (load, count-down, expire), is instantiated twice: poll period and transaction timeout.
- The FSM and capture registers stay in `i2c_temp_poller`.

## Test plan
All scenarios use small bench overrides: `POLL_CYCLES`=200, `TIMEOUT_CYCLES`=50. The wrapper is replaced by a responder model.
- Reset release, `enable`=1 → first start pulse is a write, `i2c_reg_addr`=8'h03, `i2c_wr_data`=8'h80, `i2c_bus_addr`=7'h4B.
- Model returns MSB 8'h0C, LSB 8'h80 → `temp_raw`=16'h0C80, `temp_int`=25, single `temp_valid` pulse; next read start exactly 200+2 cycles later.
- Model returns 8'hF3, 8'h80 → `temp_raw`=16'hF380, `temp_int`=-25 (9'h1E7).
- Error on the LSB read once → next start is to register 8'h00; one `temp_valid` total, with the retried values.
- No done/error ever → after 4 timeouts `fault`=1; after 200 cycles `fault`=0 and the configuration write is reissued.
- `enable` dropped during the MSB wait → LSB read still completes, `temp_valid` pulses, then no further start pulses; reset asserted mid-read → all outputs return to reset values next cycle.
